btn_event_unit: RTL and testbench

- Parametrised successor to the per-button pulse generators and game clock divider in the game top level.
- Conditions CHANNELS raw push-buttons: 2-flop synchroniser, tick-based debounce, per-channel press pulse, and optional auto-repeat.
- Merges all presses into a single-entry event register with a valid/ready handshake, so game logic running on the system clock consumes one direction at a time.

---
 rtl/btn_event_unit.sv | 260 ++++++++++++++++++++++++++
 tb/tb_btn_event_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/btn_event_unit.sv
// Push-button conditioner: synchroniser, tick debounce, press strobes and a one-entry event register.
// Optional auto-repeat of held buttons is enabled by defining BTN_EVT_AUTOREPEAT_EN.
module btn_event_unit #(
    parameter int CHANNELS           = 4,
    parameter int TICK_DIV           = 50000,
    parameter int DEBOUNCE_TICKS     = 10,
    parameter int ACTIVE_LOW         = 1,
    parameter int REPEAT_DELAY_TICKS = 500,
    parameter int REPEAT_RATE_TICKS  = 150,
    localparam int IDX_W             = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] btn_raw,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] btn_pulse,
    output logic                evt_valid,
    output logic [IDX_W-1:0]    evt_idx,
    input  logic                evt_ready,
    output logic                evt_overrun
);

    localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_TICKS);
    localparam logic [CHANNELS-1:0] RAW_IDLE = (ACTIVE_LOW != 0) ? {CHANNELS{1'b1}} : {CHANNELS{1'b0}};
    localparam logic [CHANNELS-1:0] VEC_ONE = CHANNELS'(1);

`ifdef BTN_EVT_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY_TICKS > REPEAT_RATE_TICKS) ? REPEAT_DELAY_TICKS : REPEAT_RATE_TICKS;
    localparam int REP_W = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_DELAY = REP_W'(REPEAT_DELAY_TICKS);
    localparam logic [REP_W-1:0] REP_RATE  = REP_W'(REPEAT_RATE_TICKS);
`endif

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DEB_PRESS = 2'd1,
        ST_HELD      = 2'd2,
        ST_DEB_REL   = 2'd3
    } state_t;

    logic [CHANNELS-1:0] sync1;
    logic [CHANNELS-1:0] sync2;
    logic [CHANNELS-1:0] pressed;
    logic [TICK_W-1:0]   tick_cnt;
    logic                tick;

    // Two-flop synchroniser; reset loads the released pin level
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= RAW_IDLE;
            sync2 <= RAW_IDLE;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    assign pressed = (ACTIVE_LOW != 0) ? ~sync2 : sync2;
    assign tick    = (tick_cnt == TICK_LAST);

    // Free-running sample tick divider
    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        state_t           state;
        state_t           state_nx;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nx;
        logic [CNT_W-1:0] cnt_inc;
        logic             level_r;
        logic             level_nx;
        logic             pulse_r;
        logic             press_nx;
`ifdef BTN_EVT_AUTOREPEAT_EN
        logic [REP_W-1:0] rep;
        logic [REP_W-1:0] rep_nx;
        logic [REP_W-1:0] rep_inc;
        logic             rep_armed;
        logic             rep_armed_nx;
`endif

        assign cnt_inc = cnt + CNT_W'(1);

        // Channel state register and registered level/strobe outputs
        always_ff @(posedge clk) begin
            if (!reset) begin
                state   <= ST_IDLE;
                cnt     <= '0;
                level_r <= 1'b0;
                pulse_r <= 1'b0;
`ifdef BTN_EVT_AUTOREPEAT_EN
                rep       <= '0;
                rep_armed <= 1'b0;
`endif
            end else begin
                state   <= state_nx;
                cnt     <= cnt_nx;
                level_r <= level_nx;
                pulse_r <= press_nx;
`ifdef BTN_EVT_AUTOREPEAT_EN
                rep       <= rep_nx;
                rep_armed <= rep_armed_nx;
`endif
            end
        end

        // Debounce next-state, evaluated only on sample ticks
        always_comb begin
            state_nx = state;
            cnt_nx   = cnt;
            press_nx = 1'b0;
`ifdef BTN_EVT_AUTOREPEAT_EN
            rep_inc      = rep + REP_W'(1);
            rep_nx       = rep;
            rep_armed_nx = rep_armed;
`endif
            if (tick) begin
                case (state)
                    ST_IDLE: begin
                        if (pressed[g]) begin
                            if (DEBOUNCE_TICKS == 1) begin
                                state_nx = ST_HELD;
                                cnt_nx   = '0;
                                press_nx = 1'b1;
                            end else begin
                                state_nx = ST_DEB_PRESS;
                                cnt_nx   = CNT_W'(1);
                            end
                        end else begin
                            cnt_nx = '0;
                        end
                    end
                    ST_DEB_PRESS: begin
                        if (!pressed[g]) begin
                            state_nx = ST_IDLE;
                            cnt_nx   = '0;
                        end else if (cnt_inc == DEB_LAST) begin
                            state_nx = ST_HELD;
                            cnt_nx   = '0;
                            press_nx = 1'b1;
                        end else begin
                            cnt_nx = cnt_inc;
                        end
                    end
                    ST_HELD: begin
                        if (!pressed[g]) begin
                            if (DEBOUNCE_TICKS == 1) begin
                                state_nx = ST_IDLE;
                                cnt_nx   = '0;
                            end else begin
                                state_nx = ST_DEB_REL;
                                cnt_nx   = CNT_W'(1);
                            end
                        end else begin
`ifdef BTN_EVT_AUTOREPEAT_EN
                            // First repeat waits the long delay, later ones use the rate
                            if (rep_inc == (rep_armed ? REP_RATE : REP_DELAY)) begin
                                press_nx     = 1'b1;
                                rep_nx       = '0;
                                rep_armed_nx = 1'b1;
                            end else begin
                                rep_nx = rep_inc;
                            end
`else
                            cnt_nx = '0;
`endif
                        end
                    end
                    ST_DEB_REL: begin
                        if (pressed[g]) begin
                            state_nx = ST_HELD;
                            cnt_nx   = '0;
                        end else if (cnt_inc == DEB_LAST) begin
                            state_nx = ST_IDLE;
                            cnt_nx   = '0;
                        end else begin
                            cnt_nx = cnt_inc;
                        end
                    end
                    default: begin
                        state_nx = ST_IDLE;
                        cnt_nx   = '0;
                    end
                endcase
            end else begin
                state_nx = state;
            end
`ifdef BTN_EVT_AUTOREPEAT_EN
            // Any stay outside HELD (including a release bounce) restarts the delay
            if (state_nx != ST_HELD) begin
                rep_nx       = '0;
                rep_armed_nx = 1'b0;
            end else begin
                rep_nx = rep_nx;
            end
`endif
            level_nx = (state_nx == ST_HELD) || (state_nx == ST_DEB_REL);
        end

        assign btn_level[g] = level_r;
        assign btn_pulse[g] = pulse_r;
    end

    logic             cand_any;
    logic             cand_multi;
    logic [IDX_W-1:0] cand_idx;
    logic             can_load;
    logic             valid_nx;
    logic [IDX_W-1:0] idx_nx;
    logic             overrun_nx;

    // Lowest-index arbitration and single-entry load/drop decision
    always_comb begin
        cand_any   = |btn_pulse;
        cand_multi = |(btn_pulse & (btn_pulse - VEC_ONE));
        cand_idx   = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (btn_pulse[i]) begin
                cand_idx = IDX_W'(i);
            end else begin
                cand_idx = cand_idx;
            end
        end
        can_load = !evt_valid || evt_ready;
        if (can_load) begin
            valid_nx   = cand_any;
            idx_nx     = cand_any ? cand_idx : evt_idx;
            overrun_nx = cand_multi;
        end else begin
            valid_nx   = 1'b1;
            idx_nx     = evt_idx;
            overrun_nx = cand_any;
        end
    end

    // Event entry and overrun strobe registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            evt_valid   <= 1'b0;
            evt_idx     <= '0;
            evt_overrun <= 1'b0;
        end else begin
            evt_valid   <= valid_nx;
            evt_idx     <= idx_nx;
            evt_overrun <= overrun_nx;
        end
    end

endmodule

// File: tb/tb_btn_event_unit.sv
// Directed and random bench for btn_event_unit against a run-length debounce reference model.
module tb_btn_event_unit;

    localparam int CH = 4;
    localparam int TD = 4;
    localparam int DB = 3;
    localparam int RD = 5;
    localparam int RR = 2;
`ifdef BTN_EVT_AUTOREPEAT_EN
    localparam int EXP_HOLD_PULSES = 5;
`else
    localparam int EXP_HOLD_PULSES = 1;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] btn_raw;
    logic [CH-1:0] btn_level;
    logic [CH-1:0] btn_pulse;
    logic          evt_valid;
    logic [1:0]    evt_idx;
    logic          evt_ready;
    logic          evt_overrun;

    always #5 clk = ~clk;

    btn_event_unit #(
        .CHANNELS(CH), .TICK_DIV(TD), .DEBOUNCE_TICKS(DB), .ACTIVE_LOW(1),
        .REPEAT_DELAY_TICKS(RD), .REPEAT_RATE_TICKS(RR)
    ) dut (
        .clk(clk), .reset(reset), .btn_raw(btn_raw), .btn_level(btn_level),
        .btn_pulse(btn_pulse), .evt_valid(evt_valid), .evt_idx(evt_idx),
        .evt_ready(evt_ready), .evt_overrun(evt_overrun)
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [CH-1:0] m_sync1, m_sync2, m_level, m_pulse;
    int            m_tcnt;
    int            m_run[CH];
    int            m_age[CH];
    logic          m_valid, m_ovr;
    int            m_idx;
    int            pc[CH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest(input logic [CH-1:0] p);
        for (int i = 0; i < CH; i++) if (p[i]) return i;
        return 0;
    endfunction

    task automatic model_update();
        logic [CH-1:0] prs;
        logic [CH-1:0] np;
        bit            tk;
        int            n;
        if (!reset) begin
            m_sync1 = '1; m_sync2 = '1; m_level = '0; m_pulse = '0;
            m_tcnt = 0; m_valid = 1'b0; m_ovr = 1'b0; m_idx = 0;
            for (int c = 0; c < CH; c++) begin m_run[c] = 0; m_age[c] = 0; end
            return;
        end
        prs = ~m_sync2;
        tk  = (m_tcnt == TD - 1);
        np  = '0;
        if (tk) begin
            for (int c = 0; c < CH; c++) begin
                if (!m_level[c]) begin
                    if (prs[c]) begin
                        m_run[c]++;
                        if (m_run[c] == DB) begin
                            m_level[c] = 1'b1; m_run[c] = 0; m_age[c] = 0; np[c] = 1'b1;
                        end
                    end else m_run[c] = 0;
                end else begin
                    if (prs[c]) begin
                        if (m_run[c] > 0) begin
                            m_run[c] = 0; m_age[c] = 0;
                        end else begin
                            m_age[c]++;
`ifdef BTN_EVT_AUTOREPEAT_EN
                            if (m_age[c] == RD || (m_age[c] > RD && (m_age[c] - RD) % RR == 0)) np[c] = 1'b1;
`endif
                        end
                    end else begin
                        m_age[c] = 0;
                        m_run[c]++;
                        if (m_run[c] == DB) begin m_level[c] = 1'b0; m_run[c] = 0; end
                    end
                end
            end
        end
        n = $countones(m_pulse);
        if (!m_valid || evt_ready) begin
            m_ovr = (n > 1);
            if (n > 0) begin m_valid = 1'b1; m_idx = lowest(m_pulse); end
            else m_valid = 1'b0;
        end else m_ovr = (n > 0);
        m_pulse = np;
        m_sync2 = m_sync1;
        m_sync1 = btn_raw;
        m_tcnt  = tk ? 0 : m_tcnt + 1;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        chk("btn_level", 32'(btn_level), 32'(m_level));
        chk("btn_pulse", 32'(btn_pulse), 32'(m_pulse));
        chk("evt_valid", 32'(evt_valid), 32'(m_valid));
        chk("evt_overrun", 32'(evt_overrun), 32'(m_ovr));
        if (m_valid) chk("evt_idx", 32'(evt_idx), 32'(m_idx));
        for (int c = 0; c < CH; c++) if (btn_pulse[c] === 1'b1) pc[c]++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic clear_tally();
        for (int c = 0; c < CH; c++) pc[c] = 0;
    endtask

    task automatic wait_pulse(input logic [CH-1:0] mask, input string tag);
        int k = 0;
        while ((btn_pulse & mask) == '0 && k < 40) begin step(); k++; end
        chk(tag, 32'((btn_pulse & mask) != '0), 32'd1);
    endtask

    initial begin
        reset = 1'b0; btn_raw = 4'b0000; evt_ready = 1'b1;
        run(3);
        chk("reset_outputs", 32'({btn_level, btn_pulse, evt_valid, evt_idx, evt_overrun}), 32'd0);
        reset = 1'b1; btn_raw = 4'b1111;
        clear_tally();
        run(1);
        chk("post_reset_outputs", 32'({btn_level, btn_pulse, evt_valid, evt_idx, evt_overrun}), 32'd0);
        run(13);
        chk("no_early_pulse", 32'(pc[0] + pc[1] + pc[2] + pc[3]), 32'd0);

        // clean press on channel 2
        clear_tally();
        btn_raw[2] = 1'b0;
        wait_pulse(4'b0100, "clean_pulse_seen");
        chk("clean_pulse", 32'(btn_pulse), 32'b0100);
        step();
        chk("clean_evt_valid", 32'(evt_valid), 32'd1);
        chk("clean_evt_idx", 32'(evt_idx), 32'd2);
        chk("clean_level", 32'(btn_level[2]), 32'd1);
        step();
        chk("clean_evt_consumed", 32'(evt_valid), 32'd0);
        run(22);
        clear_tally();
        btn_raw[2] = 1'b1;
        run(30);
        chk("clean_release_level", 32'(btn_level[2]), 32'd0);
        chk("clean_release_nopulse", 32'(pc[2]), 32'd0);

        // bouncing press on channel 0
        clear_tally();
        btn_raw[0] = 1'b0; run(8);
        btn_raw[0] = 1'b1; run(4);
        btn_raw[0] = 1'b0; run(20);
        btn_raw[0] = 1'b1; run(30);
        chk("bounce_pulses", 32'(pc[0]), 32'd1);

        // simultaneous presses on channels 1 and 3
        btn_raw = 4'b0101;
        wait_pulse(4'b1010, "simul_pulse_seen");
        chk("simul_pulse", 32'(btn_pulse), 32'b1010);
        step();
        chk("simul_idx", 32'(evt_idx), 32'd1);
        chk("simul_overrun", 32'(evt_overrun), 32'd1);
        btn_raw = 4'b1111;
        run(30);

        // backpressure: entry stays on ch0, ch3 press is dropped
        evt_ready = 1'b0;
        btn_raw = 4'b1110;
        wait_pulse(4'b0001, "bp_pulse0_seen");
        step();
        chk("bp_valid", 32'(evt_valid), 32'd1);
        chk("bp_idx0", 32'(evt_idx), 32'd0);
        btn_raw = 4'b0110;
        wait_pulse(4'b1000, "bp_pulse3_seen");
        step();
        chk("bp_overrun", 32'(evt_overrun), 32'd1);
        chk("bp_idx_stable", 32'(evt_idx), 32'd0);
        evt_ready = 1'b1;
        step();
        chk("bp_drain", 32'(evt_valid), 32'd0);
        btn_raw = 4'b1111;
        run(30);

        // long hold on channel 1: repeats only with the auto-repeat build
        clear_tally();
        btn_raw[1] = 1'b0;
        wait_pulse(4'b0010, "hold_pulse_seen");
        run(48);
        chk("hold_pulses", 32'(pc[1]), 32'(EXP_HOLD_PULSES));
        btn_raw[1] = 1'b1;
        run(30);

        // random pin activity and consumer stalls, with a reset in the middle
        for (int cyc = 0; cyc < 2500; cyc++) begin
            for (int c = 0; c < CH; c++) if ($urandom_range(15) == 0) btn_raw[c] = ~btn_raw[c];
            evt_ready = ($urandom_range(3) != 0);
            reset = !(cyc >= 1200 && cyc < 1202);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
